// File: rtl/udma_filter_tx_datafetch.sv
// Read-side DMA engine of the uDMA filter block.
// Issues L2 read requests following a linear, sliding-window, circular or 2D
// address pattern, buffers the returned words in a small FIFO and replays them
// in order as a valid/ready stream with start/end-of-frame markers.
// Requests are credit-limited so the FIFO always has room for every word in flight.
module udma_filter_tx_datafetch #(
    parameter int DATA_WIDTH     = 32,
    parameter int L2_AWIDTH_NOAL = 15,
    parameter int BUFFER_DEPTH   = 4,
    parameter int TRANS_SIZE     = 16
) (
    input  logic                      clk_i,
    input  logic                      resetn_i,

    output logic                      tx_ch_req_o,
    output logic [L2_AWIDTH_NOAL-1:0] tx_ch_addr_o,
    output logic [1:0]                tx_ch_datasize_o,
    input  logic                      tx_ch_gnt_i,
    input  logic                      tx_ch_valid_i,
    input  logic [DATA_WIDTH-1:0]     tx_ch_data_i,
    output logic                      tx_ch_ready_o,

    input  logic                      cmd_start_i,
    output logic                      cmd_done_o,

    input  logic [L2_AWIDTH_NOAL-1:0] cfg_start_addr_i,
    input  logic [1:0]                cfg_datasize_i,
    input  logic [1:0]                cfg_mode_i,
    input  logic [TRANS_SIZE-1:0]     cfg_len0_i,
    input  logic [TRANS_SIZE-1:0]     cfg_len1_i,
    input  logic [TRANS_SIZE-1:0]     cfg_len2_i,

    output logic [DATA_WIDTH-1:0]     stream_data_o,
    output logic                      stream_valid_o,
    output logic                      stream_sof_o,
    output logic                      stream_eof_o,
    input  logic                      stream_ready_i
);

    localparam int AW = L2_AWIDTH_NOAL;
    localparam int CW = $clog2(BUFFER_DEPTH + 1);
    localparam int PW = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1;

    localparam logic [1:0] MODE_LINEAR  = 2'd0;
    localparam logic [1:0] MODE_SLIDING = 2'd1;
    localparam logic [1:0] MODE_2D      = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t                  r_state;
    logic [1:0]              r_mode;
    logic [1:0]              r_datasize;
    logic [AW-1:0]           r_base;
    logic [AW-1:0]           r_addr;
    logic [TRANS_SIZE-1:0]   r_len0;
    logic [TRANS_SIZE-1:0]   r_len1;
    logic [TRANS_SIZE-1:0]   r_len2;
    logic [TRANS_SIZE-1:0]   r_w;
    logic [TRANS_SIZE-1:0]   r_l;
    logic [TRANS_SIZE-1:0]   r_ow;
    logic [TRANS_SIZE-1:0]   r_ol;
    logic [CW-1:0]           r_outstanding;
    logic [CW-1:0]           r_count;
    logic [PW-1:0]           r_wr_ptr;
    logic [PW-1:0]           r_rd_ptr;
    logic [DATA_WIDTH-1:0]   r_mem [BUFFER_DEPTH];

    logic [AW-1:0] w_inc;
    logic [AW-1:0] w_next_base;
    logic          w_start;
    logic          w_credit;
    logic          w_req;
    logic          w_grant;
    logic          w_line_end;
    logic          w_last_req;
    logic          w_take;
    logic          w_empty;
    logic          w_pop;
    logic          w_push;
    logic          w_out_line_end;
    logic          w_out_last;
    logic          w_eof_hs;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(BUFFER_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Element size in bytes; the reserved datasize encoding freezes the address.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_inc = '0;
        case (r_datasize)
            2'b00:   w_inc = AW'(1);
            2'b01:   w_inc = AW'(2);
            2'b10:   w_inc = AW'(4);
            default: w_inc = '0;
        endcase
    end

    // Start address of the next line: window slides by one element, 2D steps by the row stride.
    always_comb begin
        w_next_base = r_base;
        case (r_mode)
            MODE_SLIDING: w_next_base = r_base + w_inc;
            MODE_2D:      w_next_base = r_base + AW'(r_len2);
            default:      w_next_base = r_base;
        endcase
    end

    assign w_start    = (r_state == ST_IDLE) && cmd_start_i;
    assign w_credit   = ({1'b0, r_outstanding} + {1'b0, r_count}) < (CW + 1)'(BUFFER_DEPTH);
    assign w_req      = (r_state == ST_FETCH) && w_credit;
    assign w_grant    = w_req && tx_ch_gnt_i;
    assign w_line_end = (r_w == r_len0);
    assign w_last_req = w_line_end && ((r_mode == MODE_LINEAR) || (r_l == r_len1));

    // Returns are only meaningful while a transfer is running.
    assign w_take  = tx_ch_valid_i && (r_state != ST_IDLE);
    assign w_empty = (r_count == '0);
    assign w_pop   = !w_empty && stream_ready_i;
    assign w_push  = w_take && ((r_count != CW'(BUFFER_DEPTH)) || w_pop);

    assign w_out_line_end = (r_ow == r_len0);
    assign w_out_last     = w_out_line_end && ((r_mode == MODE_LINEAR) || (r_ol == r_len1));
    assign w_eof_hs       = w_pop && w_out_last;

    assign tx_ch_req_o      = w_req;
    assign tx_ch_addr_o     = r_addr;
    assign tx_ch_datasize_o = r_datasize;
    assign tx_ch_ready_o    = 1'b1;
    assign cmd_done_o       = (r_state == ST_DRAIN) && w_eof_hs;

    assign stream_valid_o = !w_empty;
    assign stream_data_o  = w_empty ? '0 : r_mem[r_rd_ptr];
    assign stream_sof_o   = !w_empty && (r_ow == '0) && (r_ol == '0);
    assign stream_eof_o   = !w_empty && w_out_last;

    // Transfer sequencing and request address generation.
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            r_state    <= ST_IDLE;
            r_mode     <= '0;
            r_datasize <= '0;
            r_base     <= '0;
            r_addr     <= '0;
            r_len0     <= '0;
            r_len1     <= '0;
            r_len2     <= '0;
            r_w        <= '0;
            r_l        <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cmd_start_i) begin
                        r_mode     <= cfg_mode_i;
                        r_datasize <= cfg_datasize_i;
                        r_base     <= cfg_start_addr_i;
                        r_addr     <= cfg_start_addr_i;
                        r_len0     <= cfg_len0_i;
                        r_len1     <= cfg_len1_i;
                        r_len2     <= cfg_len2_i;
                        r_w        <= '0;
                        r_l        <= '0;
                        r_state    <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (w_grant) begin
                        if (w_last_req) begin
                            r_state <= ST_DRAIN;
                        end
                        if (!w_line_end) begin
                            r_w    <= r_w + 1'b1;
                            r_addr <= r_addr + w_inc;
                        end else begin
                            r_w    <= '0;
                            r_l    <= r_l + 1'b1;
                            r_base <= w_next_base;
                            r_addr <= w_next_base;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (w_eof_hs) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Credit, FIFO bookkeeping and output beat position.
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            r_outstanding <= '0;
            r_count       <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_ow          <= '0;
            r_ol          <= '0;
        end else if (w_start) begin
            r_outstanding <= '0;
            r_count       <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_ow          <= '0;
            r_ol          <= '0;
        end else begin
            case ({w_grant, w_take})
                2'b10:   r_outstanding <= r_outstanding + 1'b1;
                2'b01:   if (r_outstanding != '0) r_outstanding <= r_outstanding - 1'b1;
                default: r_outstanding <= r_outstanding;
            endcase

            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end

            if (w_push) r_wr_ptr <= ptr_next(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= ptr_next(r_rd_ptr);

            if (w_pop) begin
                if (w_out_line_end) begin
                    r_ow <= '0;
                    r_ol <= (r_ol == r_len1) ? '0 : r_ol + 1'b1;
                end else begin
                    r_ow <= r_ow + 1'b1;
                end
            end
        end
    end

    // Return-data storage.
    always_ff @(posedge clk_i) begin
        // NOTE: the storage array has no reset; stream_data_o is gated by valid so stale words never leak.
        if (w_push) begin
            r_mem[r_wr_ptr] <= tx_ch_data_i;
        end
    end

endmodule
